coinc_counter: RTL and testbench

COINC_COUNTER -- requirements
Module: coinc_counter

---
 rtl/coinc_counter.sv | 264 ++++++++++++++++++++++++++
 tb/tb_coinc_counter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/coinc_counter.sv
// coinc_counter: two-channel coincidence counter with a gated integration run
// and a valid/ready result handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   det_a, det_b          asynchronous detector pulses (min 2 clk high)
//   gate_len [GATE_W]     integration length in clk cycles, sampled on start
//   start                 request a run (accepted in IDLE only)
//   busy                  high in COUNT
//   valid / ready         result handshake
//   cnt_a, cnt_b, cnt_ab  singles A, singles B, coincidences of the last run
//   cnt_acc               accidental coincidences (only with COINC_ACCIDENTAL_EN)
//   overflow              some counter of the last run saturated
//
// Optional feature macro: COINC_ACCIDENTAL_EN adds cnt_acc, which counts
// coincidences between B and A delayed by 2*WIN_CYC+1 cycles.
module coinc_counter #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned GATE_W  = 32,
  parameter int unsigned WIN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              det_a,
  input  logic              det_b,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  output logic              busy,
  output logic              valid,
  input  logic              ready,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_ab,
`ifdef COINC_ACCIDENTAL_EN
  output logic [CNT_W-1:0]  cnt_acc,
`endif
  output logic              overflow
);

  localparam int unsigned WIN_W = 4;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WIN_CYC);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [1:0]          rst_sync_q, rst_sync_d;
  logic [2:0]          sync_a_q, sync_a_d;
  logic [2:0]          sync_b_q, sync_b_d;
  logic [WIN_W-1:0]    win_a_q, win_a_d;
  logic [WIN_W-1:0]    win_b_q, win_b_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [CNT_W-1:0]    run_a_q, run_a_d;
  logic [CNT_W-1:0]    run_b_q, run_b_d;
  logic [CNT_W-1:0]    run_ab_q, run_ab_d;
  logic                run_ovf_q, run_ovf_d;
  logic [CNT_W-1:0]    out_a_q, out_a_d;
  logic [CNT_W-1:0]    out_b_q, out_b_d;
  logic [CNT_W-1:0]    out_ab_q, out_ab_d;
  logic                out_ovf_q, out_ovf_d;
  logic                valid_q, valid_d;

  logic in_count;
  logic run_en;
  logic edge_a;
  logic edge_b;
  logic coinc;
  logic ovf_a, ovf_b, ovf_ab;

  // Saturating increment; the top bit reports an increment lost at full scale.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c,
                                              input logic en);
    if (!en)
      return {1'b0, c};
    else if (c == '1)
      return {1'b1, c};
    else
      return {1'b0, c + CNT_W'(1)};
  endfunction

  assign in_count = (state_q == S_COUNT);
  // Start requests are honoured only once reset release has been synchronized.
  assign run_en   = rst_sync_q[1];
  // Bits [1:0] synchronize, bit [2] holds the previous level for edge detection.
  assign edge_a   = sync_a_q[1] & ~sync_a_q[2] & in_count;
  assign edge_b   = sync_b_q[1] & ~sync_b_q[2] & in_count;
  assign coinc    = (edge_a && (edge_b || (win_b_q != '0))) ||
                    (edge_b && (win_a_q != '0));

`ifdef COINC_ACCIDENTAL_EN
  localparam int unsigned DLY = 2 * WIN_CYC + 1;

  logic [DLY-1:0]    dly_q, dly_d;
  logic [WIN_W-1:0]  win_ad_q, win_ad_d;
  logic [WIN_W-1:0]  win_bd_q, win_bd_d;
  logic [CNT_W-1:0]  run_acc_q, run_acc_d;
  logic [CNT_W-1:0]  out_acc_q, out_acc_d;
  logic              edge_ad;
  logic              acc_coinc;
  logic              ovf_acc;

  assign edge_ad   = dly_q[DLY-1] & in_count;
  assign acc_coinc = (edge_ad && (edge_b || (win_bd_q != '0))) ||
                     (edge_b && (win_ad_q != '0));
  assign cnt_acc   = out_acc_q;
`endif

  always_comb begin
    state_d    = state_q;
    rst_sync_d = {rst_sync_q[0], 1'b1};
    sync_a_d   = {sync_a_q[1:0], det_a};
    sync_b_d   = {sync_b_q[1:0], det_b};
    gate_d     = gate_q;
    valid_d    = valid_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    out_ab_d   = out_ab_q;
    out_ovf_d  = out_ovf_q;

    win_a_d = (win_a_q != '0) ? win_a_q - WIN_W'(1) : '0;
    win_b_d = (win_b_q != '0) ? win_b_q - WIN_W'(1) : '0;
    if (edge_a) win_a_d = WIN_LOAD;
    if (edge_b) win_b_d = WIN_LOAD;
    if (coinc) begin
      win_a_d = '0;
      win_b_d = '0;
    end

    {ovf_a,  run_a_d}  = sat_inc(run_a_q,  edge_a);
    {ovf_b,  run_b_d}  = sat_inc(run_b_q,  edge_b);
    {ovf_ab, run_ab_d} = sat_inc(run_ab_q, coinc);
    run_ovf_d = run_ovf_q | ovf_a | ovf_b | ovf_ab;

`ifdef COINC_ACCIDENTAL_EN
    dly_d     = {dly_q[DLY-2:0], edge_a};
    out_acc_d = out_acc_q;
    win_ad_d  = (win_ad_q != '0) ? win_ad_q - WIN_W'(1) : '0;
    win_bd_d  = (win_bd_q != '0) ? win_bd_q - WIN_W'(1) : '0;
    if (edge_ad) win_ad_d = WIN_LOAD;
    if (edge_b)  win_bd_d = WIN_LOAD;
    if (acc_coinc) begin
      win_ad_d = '0;
      win_bd_d = '0;
    end
    {ovf_acc, run_acc_d} = sat_inc(run_acc_q, acc_coinc);
    run_ovf_d = run_ovf_d | ovf_acc;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start && run_en) begin
          run_a_d   = '0;
          run_b_d   = '0;
          run_ab_d  = '0;
          run_ovf_d = 1'b0;
          win_a_d   = '0;
          win_b_d   = '0;
`ifdef COINC_ACCIDENTAL_EN
          run_acc_d = '0;
          dly_d     = '0;
          win_ad_d  = '0;
          win_bd_d  = '0;
`endif
          if (gate_len == '0) begin
            // Empty run: publish an all-zero result straight away.
            state_d   = S_HOLD;
            valid_d   = 1'b1;
            out_a_d   = '0;
            out_b_d   = '0;
            out_ab_d  = '0;
            out_ovf_d = 1'b0;
`ifdef COINC_ACCIDENTAL_EN
            out_acc_d = '0;
`endif
          end else begin
            gate_d  = gate_len;
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        gate_d = gate_q - GATE_W'(1);
        if (gate_q == GATE_W'(1)) begin
          // Publish next-state values so final-cycle edges are included.
          state_d   = S_HOLD;
          valid_d   = 1'b1;
          out_a_d   = run_a_d;
          out_b_d   = run_b_d;
          out_ab_d  = run_ab_d;
          out_ovf_d = run_ovf_d;
`ifdef COINC_ACCIDENTAL_EN
          out_acc_d = run_acc_d;
`endif
        end
      end
      S_HOLD: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rst_sync_q <= '0;
      sync_a_q   <= '0;
      sync_b_q   <= '0;
      win_a_q    <= '0;
      win_b_q    <= '0;
      gate_q     <= '0;
      run_a_q    <= '0;
      run_b_q    <= '0;
      run_ab_q   <= '0;
      run_ovf_q  <= 1'b0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      out_ab_q   <= '0;
      out_ovf_q  <= 1'b0;
      valid_q    <= 1'b0;
`ifdef COINC_ACCIDENTAL_EN
      dly_q      <= '0;
      win_ad_q   <= '0;
      win_bd_q   <= '0;
      run_acc_q  <= '0;
      out_acc_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rst_sync_q <= rst_sync_d;
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      win_a_q    <= win_a_d;
      win_b_q    <= win_b_d;
      gate_q     <= gate_d;
      run_a_q    <= run_a_d;
      run_b_q    <= run_b_d;
      run_ab_q   <= run_ab_d;
      run_ovf_q  <= run_ovf_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      out_ab_q   <= out_ab_d;
      out_ovf_q  <= out_ovf_d;
      valid_q    <= valid_d;
`ifdef COINC_ACCIDENTAL_EN
      dly_q      <= dly_d;
      win_ad_q   <= win_ad_d;
      win_bd_q   <= win_bd_d;
      run_acc_q  <= run_acc_d;
      out_acc_q  <= out_acc_d;
`endif
    end
  end

  assign busy     = in_count;
  assign valid    = valid_q;
  assign cnt_a    = out_a_q;
  assign cnt_b    = out_b_q;
  assign cnt_ab   = out_ab_q;
  assign overflow = out_ovf_q;

endmodule

// File: tb/tb_coinc_counter.sv
// Directed bench for coinc_counter (CNT_W=4, WIN_CYC=4, GATE_W=32).
module tb_coinc_counter;

  logic        clk;
  logic        rst_n;
  logic        det_a;
  logic        det_b;
  logic [31:0] gate_len;
  logic        start;
  logic        busy;
  logic        valid;
  logic        ready;
  logic [3:0]  cnt_a;
  logic [3:0]  cnt_b;
  logic [3:0]  cnt_ab;
`ifdef COINC_ACCIDENTAL_EN
  logic [3:0]  cnt_acc;
`endif
  logic        overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  coinc_counter #(.CNT_W(4), .GATE_W(32), .WIN_CYC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .det_a    (det_a),
    .det_b    (det_b),
    .gate_len (gate_len),
    .start    (start),
    .busy     (busy),
    .valid    (valid),
    .ready    (ready),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b),
    .cnt_ab   (cnt_ab),
`ifdef COINC_ACCIDENTAL_EN
    .cnt_acc  (cnt_acc),
`endif
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int unsigned limit);
    int unsigned n = 0;
    while (valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk("valid_timeout", valid, 1);
  endtask

  // Start a run, play the pulse masks (bit i = level in cycle i), wait for valid.
  task automatic run(input logic [31:0] len, input logic [31:0] am,
                     input logic [31:0] bm, input int unsigned seqlen,
                     input int unsigned reps);
    int unsigned t0;
    gate_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    chk("run_busy", busy, 1);
    for (int unsigned r = 0; r < reps; r++)
      for (int unsigned i = 0; i < seqlen; i++) begin
        det_a = am[i];
        det_b = bm[i];
        tick();
      end
    det_a = 1'b0;
    det_b = 1'b0;
    wait_valid(len + 20);
    chk("run_len", cyc - t0, len);
    chk("run_busy_done", busy, 0);
  endtask

  task automatic ack();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("ack_valid", valid, 0);
    chk("ack_busy", busy, 0);
  endtask

  task automatic chk_cnt(input logic [3:0] ea, input logic [3:0] eb,
                         input logic [3:0] eab, input logic eovf);
    chk("cnt_a", cnt_a, ea);
    chk("cnt_b", cnt_b, eb);
    chk("cnt_ab", cnt_ab, eab);
    chk("overflow", overflow, eovf);
  endtask

  initial begin
    logic saw_valid;
    rst_n = 1'b0;
    det_a = 1'b0;
    det_b = 1'b0;
    gate_len = '0;
    start = 1'b0;
    ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk_cnt(0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // B edge 3 cycles after A: inside the 4-cycle window
    run(100, 32'h3, 32'h18, 8, 1);
    chk_cnt(1, 1, 1, 0);
    ack();

    // Empty run publishes zeros one cycle after start
    gate_len = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("gate0_valid", valid, 1);
    chk("gate0_busy", busy, 0);
    chk_cnt(0, 0, 0, 0);
    ack();

    // B 5 cycles after A: window expired
    run(100, 32'h3, 32'h60, 10, 1);
    chk_cnt(1, 1, 0, 0);
    ack();

    // Simultaneous edges
    run(100, 32'h3, 32'h3, 4, 1);
    chk_cnt(1, 1, 1, 0);
    ack();

    // B 4 cycles after A: last window cycle
    run(100, 32'h3, 32'h30, 8, 1);
    chk_cnt(1, 1, 1, 0);
    ack();

    // B@0, A@1 coincide and clear both windows, so B@4 finds no A window
    run(100, 32'h6, 32'h33, 8, 1);
    chk_cnt(1, 2, 1, 0);
    ack();

`ifdef COINC_ACCIDENTAL_EN
    // B 10 cycles after A matches A delayed by 9
    run(100, 32'h3, 32'hC00, 14, 1);
    chk_cnt(1, 1, 0, 0);
    chk("cnt_acc", cnt_acc, 1);
    ack();
`endif

    // 20 A edges saturate a 4-bit counter
    run(100, 32'h3, 32'h0, 4, 20);
    chk_cnt(15, 0, 0, 1);
    ack();

    // Next run clears overflow
    run(100, 32'h3, 32'h0, 4, 3);
    chk_cnt(3, 0, 0, 0);

    // Result held for 50 cycles with ready low; start and pulses ignored
    for (int unsigned k = 0; k < 50; k++) begin
      start = (k % 10 == 5);
      det_a = (k % 4 < 2);
      tick();
      if (k % 10 == 9) begin
        chk("hold_valid", valid, 1);
        chk("hold_busy", busy, 0);
        chk("hold_cnt_a", cnt_a, 3);
      end
    end
    det_a = 1'b0;
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b0;
    chk("hs_start_valid", valid, 0);
    chk("hs_start_busy", busy, 0);
    tick();
    chk("hs_start_ignored", busy, 0);

    // Reset in the middle of a run
    gate_len = 32'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rrun_busy", busy, 1);
    for (int unsigned k = 0; k < 39; k++) begin
      det_a = (k % 4 < 2);
      tick();
    end
    det_a = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", valid, 0);
    chk_cnt(0, 0, 0, 0);
`ifdef COINC_ACCIDENTAL_EN
    chk("mrst_acc", cnt_acc, 0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int unsigned k = 0; k < 120; k++) begin
      tick();
      if (valid === 1'b1) saw_valid = 1'b1;
    end
    chk("mrst_no_valid", saw_valid, 0);

    // Recovery run after reset
    run(20, 32'h3, 32'h3, 4, 1);
    chk_cnt(1, 1, 1, 0);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
